rr_arbiter_4: RTL and testbench

//  Round-robin arbiter that shares one resource among 4 requesters.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_arbiter_4_if.sv | 29 ++
 rtl/rr_next_idx.sv | 45 ++++
 rtl/rr_arbiter_4.sv | 132 +++++++++++++
 tb/tb_rr_arbiter_4.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
//   N_REQ        : number of requesters
//   IDX_W        : width of a requester index
//   arb_state_e  : arbiter FSM states
//   idx_to_onehot: index-to-one-hot decode used for the grant vector
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // One-hot decode of a requester index (2-to-4 decoder style).
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between requesting blocks and the arbiter.
//   en      : arbiter enable
//   req     : level-sensitive request per requester
//   lock    : owner asks for no preemption (honoured only with ARB_LOCK_EN)
//   gnt     : registered one-hot grant
//   gnt_idx : binary index of the current owner
//   gnt_vld : grant present
// master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic             lock;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;

  modport master (
    output en, req, lock,
    input  gnt, gnt_idx, gnt_vld
  );

  modport slave (
    input  en, req, lock,
    output gnt, gnt_idx, gnt_vld
  );

endinterface

// File: rtl/rr_next_idx.sv
// Combinational circular priority picker.
// Searches req starting at start_idx and wrapping, optionally masking one
// requester (excl_idx), and reports the first set bit.
//   req       : request vector
//   start_idx : highest-priority position for this search
//   excl_en   : enable masking of excl_idx
//   excl_idx  : requester to skip
//   found     : some unmasked request exists
//   idx       : index of the winner (start_idx when nothing found)
module rr_next_idx
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] masked;

  always_comb begin
    masked = req;
    if (excl_en) begin
      masked[excl_idx] = 1'b0;
    end
  end

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = '0;
    found = 1'b0;
    idx   = start_idx;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = start_idx + IDX_W'(i);
      if (masked[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter sharing one resource among 4 requesters.
// Grants are registered one-hot, held while the owner keeps requesting,
// and rotated after MAX_HOLD cycles when someone else is waiting
// (MAX_HOLD = 0 disables the limit).
// Build option: ARB_LOCK_EN -- when defined, lock=1 suppresses the hold
// timeout; otherwise lock is ignored.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : rr_arbiter_4_if.slave (en, req, lock in; gnt, gnt_idx, gnt_vld out)
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  rr_arbiter_4_if.slave   bus
);

  localparam int unsigned    CNT_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             owner_req;
  logic             lock_hold;
  logic             timeout;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

`ifdef ARB_LOCK_EN
  assign lock_hold = bus.lock;
`else
  logic lock_unused;
  assign lock_unused = bus.lock;
  assign lock_hold   = 1'b0;
`endif

  assign owner_req = bus.req[gnt_idx_q];
  assign timeout   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX) && !lock_hold;

  // Search starts after the last winner; a still-requesting owner is skipped
  // so a timeout can only rotate to someone else.
  rr_next_idx u_pick (
    .req       (bus.req),
    .start_idx (last_idx_q + IDX_W'(1)),
    .excl_en   ((state_q == ARB_BUSY) && owner_req),
    .excl_idx  (gnt_idx_q),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // State and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      last_idx_q <= IDX_W'(N_REQ - 1);
      hold_cnt_q <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_q      <= gnt_d;
    end
  end

  // Next-state, hold counter and grant selection.
  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;

    if (!bus.en) begin
      // last_idx is kept so fairness resumes where it stopped.
      state_d    = ARB_IDLE;
      gnt_vld_d  = 1'b0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            state_d    = ARB_BUSY;
            last_idx_d = pick_idx;
            gnt_idx_d  = pick_idx;
            gnt_vld_d  = 1'b1;
            hold_cnt_d = HOLD_ONE;
          end
        end
        ARB_BUSY: begin
          if (!owner_req || (timeout && pick_found)) begin
            // Release or timeout: hand over on the same edge, no bubble.
            if (pick_found) begin
              last_idx_d = pick_idx;
              gnt_idx_d  = pick_idx;
              hold_cnt_d = HOLD_ONE;
            end else begin
              state_d    = ARB_IDLE;
              gnt_vld_d  = 1'b0;
              hold_cnt_d = '0;
            end
          end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end
        default: begin
          state_d   = ARB_IDLE;
          gnt_vld_d = 1'b0;
        end
      endcase
    end
  end

  assign gnt_d = gnt_vld_d ? idx_to_onehot(gnt_idx_d) : '0;

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4 (MAX_HOLD = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_rr_arbiter_4;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check_gnt(input string tag, input logic [3:0] exp);
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(exp));
    check({tag, ".vld"}, 32'(bus.gnt_vld), 32'(exp != 4'b0));
    if (exp != 4'b0) begin
      check({tag, ".idx"}, 32'(bus.gnt_idx), 32'(enc(exp)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.req  = 4'b0;
    bus.lock = 1'b0;
    step();
    rst = 1'b0;
  endtask

  logic [3:0] t2_req [9] = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7};
  logic [3:0] t2_exp [9] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};

  initial begin
    logic [3:0] exp;

    // 1. Reset holds grants off even with every request and en high.
    do_reset();
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.req = 4'hF;
    step();
    check_gnt("t1_in_reset", 4'b0000);
    step();
    check_gnt("t1_in_reset2", 4'b0000);
    rst = 1'b0;
    step();
    check_gnt("t1_first", 4'b0001);

    // 2. Fairness with 2-cycle holds, back-to-back handovers.
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.req = t2_req[i];
      step();
      check_gnt($sformatf("t2_c%0d", i), t2_exp[i]);
    end

    // 3. Timeout rotation between two persistent requesters.
    do_reset();
    bus.en  = 1'b1;
    bus.req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step();
      exp = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
      check_gnt($sformatf("t3_c%0d", i), exp);
    end

    // 4. Sole requester is never dropped at the hold limit.
    do_reset();
    bus.en  = 1'b1;
    bus.req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step();
      check_gnt($sformatf("t4_c%0d", i), 4'b0100);
    end

    // 5. en low mid-grant, fairness resumes; async reset mid-grant.
    do_reset();
    bus.en  = 1'b1;
    bus.req = 4'b0100;
    step();
    check_gnt("t5_owner2", 4'b0100);
    bus.en = 1'b0;
    step();
    check_gnt("t5_en_low", 4'b0000);
    bus.en  = 1'b1;
    bus.req = 4'hF;
    step();
    check_gnt("t5_resume", 4'b1000);
    #2;
    rst = 1'b1;
    #1;
    check_gnt("t5_async_rst", 4'b0000);
    step();
    rst = 1'b0;
    check_gnt("t5_rst_held", 4'b0000);

    // 6. Lock suppresses timeout only when ARB_LOCK_EN is built in.
    do_reset();
    bus.en   = 1'b1;
    bus.req  = 4'b0011;
    bus.lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
`ifdef ARB_LOCK_EN
      exp = 4'b0001;
`else
      exp = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
      check_gnt($sformatf("t6_lock_c%0d", i), exp);
    end
    bus.lock = 1'b0;
    step();
`ifdef ARB_LOCK_EN
    exp = 4'b0010;
`else
    exp = 4'b0001;
`endif
    check_gnt("t6_unlock", exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
